multi_channel_pattern_gen: RTL
==============================

Name: multi_channel_pattern_gen

Overview:
Parametrised periodic pattern generator producing a data beat every (period+1) enabled cycles. Beats are round-robin distributed across NUM_CH independent channels, each with its own incrementing or decrementing data accumulator. The output is a registered valid/ready source with backpressure and drop accounting. It is used as a stimulus/traffic source feeding downstream consumers in unit tests and in the design.

Parameters:
DATA_W, 8, width of data and step
NUM_CH, 4, number of channels (>=2)
DLY_W, 8, width of period input and tick counter
RESET_VAL, 0, reset value of every channel accumulator and of data (DATA_W bits)
CH_W, $clog2(NUM_CH), width of channel output (derived, not overridable)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = tick counter runs; 0 = no ticks, counter reloads period
period  input  DLY_W  tick interval minus one; 0 = tick every cycle
step  input  DATA_W  accumulator increment/decrement amount
mode  input  1  0 = add step, 1 = subtract step; sampled at beat load
drop_clr  input  1  clears drop_count
ready  input  1  downstream accept
data  output  DATA_W  beat payload
channel  output  CH_W  channel index of current beat
valid  output  1  beat present
drop_count  output  16  saturating count of ticks lost to backpressure

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: valid=0, data=RESET_VAL, channel=0, drop_count=0. All channel accumulators = RESET_VAL. Channel pointer = 0. Tick counter = period.
- Reset has priority over everything. Asserting reset mid-beat discards the held beat; valid=0 after the reset edge.
- Tick counter, when enable=1:
  - counter==0: tick asserted this cycle, counter <= period.
  - otherwise: counter <= counter-1.
- Tick counter, when enable=0: no tick, counter <= period.
- period changes take effect at the next reload only.
- Slot free = (valid==0) or (valid && ready).
- Tick with slot free (load):
  - data <= acc[ptr], channel <= ptr, valid <= 1.
  - acc[ptr] <= acc[ptr] + step (mode 0) or acc[ptr] - step (mode 1), modulo 2^DATA_W, no saturation.
  - ptr <= ptr+1, wrapping NUM_CH-1 -> 0.
- Tick with slot not free (drop):
  - Beat dropped; accumulators and ptr unchanged.
  - drop_count increments, saturating at 0xFFFF.
- No tick and valid && ready: valid <= 0. data and channel hold their last values.
- Latency: tick in cycle N -> valid high from cycle N+1.
- Back-to-back beats at period=0 with ready=1 continuously: valid stays high, one new beat per cycle.
- While valid && !ready: data and channel are stable and valid stays high (no retraction).
- drop_clr: drop_count <= 0. drop_clr wins over a simultaneous drop increment.
- Outputs are driven directly from registers. No combinational path from ready to valid/data.

Test Plan:
(All scenarios: DATA_W=8, NUM_CH=4, RESET_VAL=0x10.)
1. Periodic round-robin
   - Stimulus: release reset; enable=1, period=3, step=1, mode=0, ready=1.
   - Response: first valid in 5th cycle after reset release, then one beat every 4 cycles. Each beat is a single-cycle valid pulse. Beat sequence (ch,data): (0,0x10),(1,0x10),(2,0x10),(3,0x10),(0,0x11),(1,0x11). drop_count=0.
2. Backpressure
   - Stimulus: period=0, ready=0 for 5 cycles after first valid, then ready=1.
   - Response: beat (0,0x10) held stable throughout, drop_count=5. After ready rises, next beat is (1,0x10), not (1,0x11).
3. Wrap-around
   - Stimulus: mode=0, step=0x80.
   - Response: channel 0 beats are 0x10, 0x90, 0x10. Mode=1 with step=0x20 gives channel 0 beats 0x10, 0xF0, 0xD0.
4. Enable gating
   - Stimulus: period=3; deassert enable for 10 cycles mid-count, then reassert.
   - Response: no valid while enable=0. First beat appears 5 cycles after enable returns (counter restarted from period).
5. Drop saturation and clear
   - Stimulus: ready=0, period=0 for 70000 cycles.
   - Response: drop_count=0xFFFF and holds. drop_clr asserted in the same cycle as a drop gives drop_count=0 next cycle.
6. Reset mid-operation
   - Stimulus: valid held with ready=0; assert reset for 1 cycle.
   - Response: next edge valid=0, drop_count=0, channel=0. After release, sequence restarts at (0,0x10) per scenario 1 timing.

Source files
------------

// File: rtl/multi_channel_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_pattern_gen
// Description : Periodic beat source that spreads beats round-robin over
//               NUM_CH accumulating channels, with a backpressured
//               valid/ready output and a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_pattern_gen #(
    parameter int                DATA_W    = 8,
    parameter int                NUM_CH    = 4,
    parameter int                DLY_W     = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int               CH_W      = $clog2(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DLY_W-1:0]  period,
    input  logic [DATA_W-1:0] step,
    input  logic              mode,
    input  logic              drop_clr,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic [CH_W-1:0]   channel,
    output logic              valid,
    output logic [15:0]       drop_count
);

    localparam logic [CH_W-1:0] c_LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [15:0]     c_DROP_MAX = 16'hFFFF;

    logic [DLY_W-1:0]  r_cnt;
    logic [CH_W-1:0]   r_ptr;
    logic [DATA_W-1:0] r_acc [NUM_CH];
    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_channel;
    logic              r_valid;
    logic [15:0]       r_drop;

    logic              w_tick;
    logic              w_slot_free;
    logic [DATA_W-1:0] w_acc_cur;
    logic [DATA_W-1:0] w_acc_next;

    assign w_tick      = enable && (r_cnt == '0);
    assign w_slot_free = !r_valid || ready;
    assign w_acc_cur   = r_acc[r_ptr];
    assign w_acc_next  = mode ? (w_acc_cur - step) : (w_acc_cur + step);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= period;
            r_ptr     <= '0;
            r_data    <= RESET_VAL;
            r_channel <= '0;
            r_valid   <= 1'b0;
            r_drop    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= RESET_VAL;
            end
        end else begin
            // Counter reloads from period only on expiry or while disabled.
            if (!enable || (r_cnt == '0)) begin
                r_cnt <= period;
            end else begin
                r_cnt <= r_cnt - DLY_W'(1);
            end

            if (w_tick && w_slot_free) begin
                r_data       <= w_acc_cur;
                r_channel    <= r_ptr;
                r_valid      <= 1'b1;
                r_acc[r_ptr] <= w_acc_next;
                r_ptr        <= (r_ptr == c_LAST_CH) ? '0 : r_ptr + CH_W'(1);
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            if (drop_clr) begin
                r_drop <= '0;
            end else if (w_tick && !w_slot_free && (r_drop != c_DROP_MAX)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign data       = r_data;
    assign channel    = r_channel;
    assign valid      = r_valid;
    assign drop_count = r_drop;

endmodule
`default_nettype wire
